// File: rtl/dpi_stream_sequencer.sv
// Maps flow keys to 6-bit stream slots and drives the shared regex matcher control
// bus. It spaces load_state, char_in and eop so every matcher sees a consistent state.
module dpi_stream_sequencer #(
  parameter int KEY_W     = 32,
  parameter int NUM_REGEX = 8,
  parameter int LOAD_GAP  = 2,
  parameter int EOP_GAP   = 2,
  parameter logic [NUM_REGEX-1:0] DEFAULT_EN = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_sop,
  input  logic                 s_eop,
  input  logic [KEY_W-1:0]     s_flow_key,
  input  logic                 cfg_wr,
  input  logic [5:0]           cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_en,
  input  logic                 flush,
  output logic                 load_state,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          evict_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_STREAM = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_EOP    = 3'd6;

  logic [2:0]           state;
  logic [7:0]           gap_cnt;
  logic [KEY_W-1:0]     key_p0;
  logic [63:0]          tbl_vld;
  logic [KEY_W-1:0]     tbl_key [64];
  logic [NUM_REGEX-1:0] tbl_en  [64];
  logic [5:0]           victim;
  logic [5:0]           slot_p1;
  logic                 new_p1;
  logic [NUM_REGEX-1:0] en_p1;
  logic [7:0]           char_p1;
  logic                 vld_p1;

  logic                 hit;
  logic [5:0]           hit_idx;
  logic                 free;
  logic [5:0]           free_idx;
  logic [5:0]           alloc_slot;
  logic                 do_alloc;
  logic [NUM_REGEX-1:0] hit_en;
  logic                 accept;

  // Parallel lookup; the descending scan leaves the lowest free index
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (tbl_vld[i] && (tbl_key[i] == key_p0)) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
      if (!tbl_vld[i]) begin
        free     = 1'b1;
        free_idx = 6'(i);
      end
    end
  end

  assign alloc_slot = free ? free_idx : victim;
  assign do_alloc   = (state == ST_LOOKUP) && !hit;
  // A cfg write landing in the lookup cycle still reaches this packet
  assign hit_en     = (cfg_wr && (cfg_addr == hit_idx)) ? cfg_en : tbl_en[hit_idx];

  assign s_ready = !rst && ((state == ST_STREAM) ||
                            ((state == ST_IDLE) && s_valid && !s_sop));
  assign accept  = (state == ST_STREAM) && s_valid;

  assign load_state    = (state == ST_LOAD);
  assign new_stream_id = (state == ST_LOAD) && new_p1;
  assign eop           = (state == ST_EOP);
  assign busy          = (state != ST_IDLE);
  assign stream_id     = slot_p1;
  assign enable        = en_p1;
  assign char_in       = char_p1;
  assign char_in_vld   = vld_p1;

  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && s_valid && s_sop && !flush)
      key_p0 <= s_flow_key;
    if (cfg_wr)
      tbl_en[cfg_addr] <= cfg_en;
    if (do_alloc) begin
      tbl_key[alloc_slot] <= key_p0;
      tbl_en[alloc_slot]  <= DEFAULT_EN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      tbl_vld   <= '0;
      victim    <= '0;
      pkt_cnt   <= '0;
      evict_cnt <= '0;
      slot_p1   <= '0;
      new_p1    <= 1'b0;
      en_p1     <= '0;
      char_p1   <= '0;
      vld_p1    <= 1'b0;
    end else begin
      // Byte stage: registered copy of each accepted byte
      vld_p1 <= accept;
      if (accept)
        char_p1 <= s_data;

      case (state)
        ST_IDLE: begin
          if (flush)
            tbl_vld <= '0;
          else if (s_valid && s_sop)
            state <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          state <= ST_LOAD;
          if (hit) begin
            slot_p1 <= hit_idx;
            new_p1  <= 1'b0;
            en_p1   <= hit_en;
          end else begin
            slot_p1             <= alloc_slot;
            new_p1              <= 1'b1;
            en_p1               <= DEFAULT_EN;
            tbl_vld[alloc_slot] <= 1'b1;
            if (!free) begin
              victim <= victim + 6'd1;
              if (evict_cnt != 16'hFFFF)
                evict_cnt <= evict_cnt + 16'd1;
            end
          end
        end
        ST_LOAD: begin
          state   <= ST_WAIT;
          gap_cnt <= '0;
        end
        ST_WAIT: begin
          if (gap_cnt == 8'(LOAD_GAP - 2))
            state <= ST_STREAM;
          else
            gap_cnt <= gap_cnt + 8'd1;
        end
        ST_STREAM: begin
          if (accept && s_eop) begin
            state   <= ST_DRAIN;
            gap_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (gap_cnt == 8'(EOP_GAP - 1))
            state <= ST_EOP;
          else
            gap_cnt <= gap_cnt + 8'd1;
        end
        ST_EOP: begin
          state   <= ST_IDLE;
          pkt_cnt <= pkt_cnt + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: slot mapping, bus spacing, eviction,
// reset and flush behaviour.
module tb_dpi_stream_sequencer;
  localparam int KEY_W = 32;
  localparam int NR    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0, s_ready, s_sop = 1'b0, s_eop = 1'b0;
  logic [7:0]    s_data = '0;
  logic [KEY_W-1:0] s_flow_key = '0;
  logic          cfg_wr = 1'b0;
  logic [5:0]    cfg_addr = '0;
  logic [NR-1:0] cfg_en = '0;
  logic          flush = 1'b0;
  logic          load_state, new_stream_id, char_in_vld, eop, busy;
  logic [5:0]    stream_id;
  logic [7:0]    char_in;
  logic [NR-1:0] enable;
  logic [15:0]   pkt_cnt, evict_cnt;

  dpi_stream_sequencer #(.KEY_W(KEY_W), .NUM_REGEX(NR), .LOAD_GAP(2), .EOP_GAP(2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sop(s_sop), .s_eop(s_eop), .s_flow_key(s_flow_key), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_en(cfg_en), .flush(flush), .load_state(load_state),
    .stream_id(stream_id), .new_stream_id(new_stream_id), .char_in(char_in),
    .char_in_vld(char_in_vld), .eop(eop), .enable(enable), .busy(busy),
    .pkt_cnt(pkt_cnt), .evict_cnt(evict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int            ld_seen, ld_cyc, eop_n, eop_cyc, stab_err;
  logic [5:0]    ld_sid;
  logic          ld_new, in_pkt;
  logic [NR-1:0] ld_en, eop_en;
  logic [7:0]    ch_q[$];
  int            chc_q[$];

  always @(negedge clk) begin
    if (load_state) begin
      ld_seen++;
      ld_cyc = cyc;
      ld_sid = stream_id;
      ld_new = new_stream_id;
      ld_en  = enable;
      in_pkt = 1'b1;
    end else if (in_pkt && ((stream_id !== ld_sid) || (enable !== ld_en))) begin
      stab_err++;
    end
    if (char_in_vld) begin
      ch_q.push_back(char_in);
      chc_q.push_back(cyc);
    end
    if (eop) begin
      eop_n++;
      eop_cyc = cyc;
      eop_en  = enable;
      in_pkt  = 1'b0;
    end
  end

  task automatic clr_mon();
    ld_seen = 0; ld_cyc = 0; eop_n = 0; eop_cyc = 0; stab_err = 0;
    ld_sid = '0; ld_new = 1'b0; ld_en = '0; eop_en = '0; in_pkt = 1'b0;
    ch_q.delete();
    chc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one packet; payload byte i is pl[8*i +: 8]; gap>0 inserts an idle cycle before byte gap
  task automatic send_pkt(input logic [KEY_W-1:0] key, input logic [31:0] pl,
                          input int n, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      if ((i == gap) && (i > 0)) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1; s_sop = (i == 0); s_eop = (i == n - 1);
      s_data = pl[8*i +: 8]; s_flow_key = key;
      t = 0;
      #1;
      while (!s_ready && (t < 40)) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (!s_ready) begin
        checks++; failures++;
        $display("FAIL ready_timeout byte=%0d s_ready=%b required=1", i, s_ready);
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic wait_eop();
    int t;
    t = 0;
    while ((eop_n == 0) && (t < 60)) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (eop_n == 0) begin
      failures++;
      $display("FAIL eop_timeout eop_count=%0d required>=1", eop_n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pkt(input logic [KEY_W-1:0] key, input logic [31:0] pl,
                         input int n, input int gap);
    clr_mon();
    send_pkt(key, pl, n, gap);
    wait_eop();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({s_ready, load_state, new_stream_id, char_in_vld, eop, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {s_ready, load_state, new_stream_id, char_in_vld, eop, busy});
    end
    checks++;
    if ({stream_id, char_in, enable} !== '0) begin
      failures++;
      $display("FAIL reset_data sid=%0d char=%h en=%h required=0", stream_id, char_in, enable);
    end
    checks++;
    if ({pkt_cnt, evict_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL reset_counters pkt=%0d evict=%0d required=0", pkt_cnt, evict_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_pkt(32'hA5A5_0001, 32'h0043_4241, 3, -1);
    checks++;
    if ((ld_seen !== 1) || (ld_sid !== 6'd0) || (ld_new !== 1'b1)) begin
      failures++;
      $display("FAIL basic_load seen=%0d sid=%0d new=%b required 1/0/1", ld_seen, ld_sid, ld_new);
    end
    checks++;
    if (ch_q.size() != 3) begin
      failures++;
      $display("FAIL basic_char_count got=%0d required=3", ch_q.size());
    end else begin
      checks++;
      if ({ch_q[0], ch_q[1], ch_q[2]} !== {8'h41, 8'h42, 8'h43}) begin
        failures++;
        $display("FAIL basic_chars got=%h%h%h required=414243", ch_q[0], ch_q[1], ch_q[2]);
      end
      checks++;
      if ((chc_q[0] - ld_cyc) < 2) begin
        failures++;
        $display("FAIL basic_load_gap got=%0d required>=2", chc_q[0] - ld_cyc);
      end
      checks++;
      if ((chc_q[2] - chc_q[0]) != 2) begin
        failures++;
        $display("FAIL basic_b2b span=%0d required=2", chc_q[2] - chc_q[0]);
      end
      checks++;
      if ((eop_cyc - chc_q[2]) != 2) begin
        failures++;
        $display("FAIL basic_eop_gap got=%0d required=2", eop_cyc - chc_q[2]);
      end
    end
    checks++;
    if ((eop_n !== 1) || (pkt_cnt !== 16'd1)) begin
      failures++;
      $display("FAIL basic_eop eops=%0d pkt_cnt=%0d required 1/1", eop_n, pkt_cnt);
    end
  endtask

  task automatic test_hit();
    run_pkt(32'hA5A5_0001, 32'h0000_0058, 1, -1);
    checks++;
    if ((ld_sid !== 6'd0) || (ld_new !== 1'b0) || (ld_en !== 8'hFF)) begin
      failures++;
      $display("FAIL hit_same_key sid=%0d new=%b en=%h required 0/0/ff", ld_sid, ld_new, ld_en);
    end
    run_pkt(32'h0000_000B, 32'h0000_0059, 1, -1);
    checks++;
    if ((ld_sid !== 6'd1) || (ld_new !== 1'b1)) begin
      failures++;
      $display("FAIL hit_new_key sid=%0d new=%b required 1/1", ld_sid, ld_new);
    end
  endtask

  task automatic test_cfg();
    cfg_wr = 1'b1; cfg_addr = 6'd0; cfg_en = 8'h05;
    @(negedge clk);
    cfg_wr = 1'b0;
    @(negedge clk);
    run_pkt(32'hA5A5_0001, 32'h0000_6261, 2, -1);
    checks++;
    if ((ld_en !== 8'h05) || (eop_en !== 8'h05)) begin
      failures++;
      $display("FAIL cfg_enable load_en=%h eop_en=%h required 05/05", ld_en, eop_en);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL cfg_stable changes=%0d required=0", stab_err);
    end
  endtask

  task automatic test_fill();
    do_reset();
    run_pkt(32'hA5A5_0001, 32'h0000_0041, 1, -1);
    for (int i = 1; i < 64; i++)
      run_pkt(32'h0000_1000 + i, 32'h0000_0030, 1, -1);
    checks++;
    if ((ld_sid !== 6'd63) || (evict_cnt !== 16'd0)) begin
      failures++;
      $display("FAIL fill_last sid=%0d evict=%0d required 63/0", ld_sid, evict_cnt);
    end
    run_pkt(32'h0000_2000, 32'h0000_0031, 1, -1);
    checks++;
    if ((ld_sid !== 6'd0) || (ld_new !== 1'b1) || (evict_cnt !== 16'd1)) begin
      failures++;
      $display("FAIL evict_first sid=%0d new=%b evict=%0d required 0/1/1", ld_sid, ld_new, evict_cnt);
    end
    run_pkt(32'h0000_2001, 32'h0000_0032, 1, -1);
    checks++;
    if ((ld_sid !== 6'd1) || (evict_cnt !== 16'd2)) begin
      failures++;
      $display("FAIL evict_second sid=%0d evict=%0d required 1/2", ld_sid, evict_cnt);
    end
    run_pkt(32'hA5A5_0001, 32'h0000_0033, 1, -1);
    checks++;
    if ((ld_new !== 1'b1) || (ld_sid !== 6'd2) || (pkt_cnt !== 16'd67)) begin
      failures++;
      $display("FAIL evicted_key_miss new=%b sid=%0d pkt=%0d required 1/2/67", ld_new, ld_sid, pkt_cnt);
    end
  endtask

  task automatic test_gap();
    run_pkt(32'h0000_000C, 32'h0000_005A, 1, -1);
    checks++;
    if ((ch_q.size() != 1) || (eop_n !== 1) || ((eop_cyc - chc_q[0]) != 2)) begin
      failures++;
      $display("FAIL single_byte chars=%0d eops=%0d required 1/1 with eop gap 2", ch_q.size(), eop_n);
    end
    run_pkt(32'h0000_000C, 32'h3433_3231, 4, 2);
    checks++;
    if (ch_q.size() != 4) begin
      failures++;
      $display("FAIL gap_char_count got=%0d required=4", ch_q.size());
    end else begin
      checks++;
      if ({ch_q[0], ch_q[1], ch_q[2], ch_q[3]} !== 32'h3132_3334) begin
        failures++;
        $display("FAIL gap_order got=%h%h%h%h required=31323334", ch_q[0], ch_q[1], ch_q[2], ch_q[3]);
      end
      checks++;
      if (((chc_q[2] - chc_q[1]) != 2) || ((chc_q[3] - chc_q[0]) != 4)) begin
        failures++;
        $display("FAIL gap_bubble d21=%0d d30=%0d required 2/4", chc_q[2] - chc_q[1], chc_q[3] - chc_q[0]);
      end
    end
    checks++;
    if (eop_n !== 1) begin
      failures++;
      $display("FAIL gap_eop_count got=%0d required=1", eop_n);
    end
  endtask

  task automatic test_rst_stream();
    int t;
    do_reset();
    run_pkt(32'hA5A5_0001, 32'h0000_0041, 1, -1);
    clr_mon();
    s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_data = 8'h51; s_flow_key = 32'hA5A5_0001;
    t = 0;
    #1;
    while (!s_ready && (t < 40)) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    s_sop = 1'b0; s_data = 8'h52;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, load_state, new_stream_id, char_in_vld, eop, busy} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid_flags got=%b required=000000",
               {s_ready, load_state, new_stream_id, char_in_vld, eop, busy});
    end
    checks++;
    if ({stream_id, char_in, enable, pkt_cnt} !== '0) begin
      failures++;
      $display("FAIL rst_mid_data sid=%0d char=%h en=%h pkt=%0d required 0",
               stream_id, char_in, enable, pkt_cnt);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (eop_n !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_eop eops=%0d required=0", eop_n);
    end
    run_pkt(32'hA5A5_0001, 32'h0000_0041, 1, -1);
    checks++;
    if ((ld_new !== 1'b1) || (ld_sid !== 6'd0)) begin
      failures++;
      $display("FAIL rst_table_cleared new=%b sid=%0d required 1/0", ld_new, ld_sid);
    end
  endtask

  task automatic test_flush();
    run_pkt(32'hA5A5_0001, 32'h0000_0041, 1, -1);
    checks++;
    if (ld_new !== 1'b0) begin
      failures++;
      $display("FAIL pre_flush_hit new=%b required=0", ld_new);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    run_pkt(32'hA5A5_0001, 32'h0000_0041, 1, -1);
    checks++;
    if ((ld_new !== 1'b1) || (ld_sid !== 6'd0)) begin
      failures++;
      $display("FAIL flush_table_cleared new=%b sid=%0d required 1/0", ld_new, ld_sid);
    end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_basic();
    test_hit();
    test_cfg();
    test_fill();
    test_gap();
    test_rst_stream();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
